// File: rtl/memory_board.sv
// -----------------------------------------------------------------------------
// memory_board
//   Game core for a two-player 4x4 "memory" (concentration) card game.
//   Sixteen slots hold 3-bit face values; matching pairs are removed, a miss
//   passes the turn. A card-value memory can be reloaded between games.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   btn_up/down/left/right : single-cycle cursor move pulses
//   btn_sel           : single-cycle pulse, select card under cursor
//   load, load_addr, load_val : card-value write port (idle board only)
//   cursor            : current slot, [3:2]=row, [1:0]=column
//   select            : one-cycle pulse per accepted btn_sel press
//   state             : {1'b0, face value} of the selected slot (held)
//   empty             : with select, 1 = legal pick (face-down, unmatched)
//   player            : player to move (0 = J1, 1 = J2)
//   revealed          : face-up mask for the current turn
//   matched           : removed-pair mask
//   pairs_left        : unmatched pairs remaining (8..0)
//   game_over         : high once every pair is matched
// -----------------------------------------------------------------------------
module memory_board #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        load,
  input  logic [3:0]  load_addr,
  input  logic [2:0]  load_val,
  output logic [3:0]  cursor,
  output logic        select,
  output logic [3:0]  state,
  output logic        empty,
  output logic        player,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic [3:0]  pairs_left,
  output logic        game_over
);

  typedef enum logic [2:0] {PICK1, PICK2, SHOW, RESOLVE, DONE} fsm_t;

  fsm_t       fsm;
  logic [2:0] cards [16];
  logic [3:0] first_slot;
  logic [3:0] second_slot;
  logic [7:0] hold_cnt;

  logic load_ok;
  logic legal;

  // Loading is only allowed on an untouched board so a game in progress can
  // never have its cards swapped underneath it.
  assign load_ok = load && (fsm == PICK1) && (revealed == '0) && (matched == '0);
  assign legal   = !matched[cursor] && !revealed[cursor];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= PICK1;
      cursor      <= '0;
      select      <= 1'b0;
      state       <= '0;
      empty       <= 1'b0;
      player      <= 1'b0;
      revealed    <= '0;
      matched     <= '0;
      pairs_left  <= 4'd8;
      game_over   <= 1'b0;
      hold_cnt    <= '0;
      first_slot  <= '0;
      second_slot <= '0;
      // NOTE: this small card store is deliberately reset (to the default
      // pair layout i>>1), so it must stay in flops; a RAM macro could not
      // be cleared here.
      for (int i = 0; i < 16; i++) cards[i] <= 3'(i >> 1);
    end else begin
      select <= 1'b0;
      case (fsm)
        PICK1, PICK2: begin
          // Priority: accepted load > sel > up > down > left > right.
          if (load_ok) begin
            cards[load_addr] <= load_val;
          end else if (btn_sel) begin
            select <= 1'b1;
            state  <= {1'b0, cards[cursor]};
            empty  <= legal;
            if (legal) begin
              revealed[cursor] <= 1'b1;
              if (fsm == PICK1) begin
                first_slot <= cursor;
                fsm        <= PICK2;
              end else begin
                second_slot <= cursor;
                hold_cnt    <= 8'(HOLD_CYCLES);
                fsm         <= SHOW;
              end
            end
          end else if (btn_up) begin
            cursor[3:2] <= cursor[3:2] - 2'd1;
          end else if (btn_down) begin
            cursor[3:2] <= cursor[3:2] + 2'd1;
          end else if (btn_left) begin
            cursor[1:0] <= cursor[1:0] - 2'd1;
          end else if (btn_right) begin
            cursor[1:0] <= cursor[1:0] + 2'd1;
          end
        end

        SHOW: begin
          // Leaves on the edge where the count would reach zero, so the pair
          // is shown for exactly HOLD_CYCLES cycles.
          if (hold_cnt <= 8'd1) fsm <= RESOLVE;
          if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end

        RESOLVE: begin
          revealed <= '0;
          if (cards[first_slot] == cards[second_slot]) begin
            matched[first_slot]  <= 1'b1;
            matched[second_slot] <= 1'b1;
            pairs_left           <= pairs_left - 4'd1;
            if (pairs_left == 4'd1) begin
              game_over <= 1'b1;
              fsm       <= DONE;
            end else begin
              fsm <= PICK1;
            end
          end else begin
            player <= ~player;
            fsm    <= PICK1;
          end
        end

        default: begin
          // DONE: frozen until reset.
        end
      endcase
    end
  end

endmodule

// File: doc/memory_board.md
MEMORY_BOARD -- requirements
Module: memory_board

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles the second revealed card stays shown before resolution (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; asserted forces reset state immediately, released synchronously to clk.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced single-cycle cursor move pulses.
REQ-005 btn_sel  input  1  debounced single-cycle pulse: select card under cursor.
REQ-006 load  input  1  write strobe for card value memory.
REQ-007 load_addr  input  4  card slot written when load=1.
REQ-008 load_val  input  3  card face value written (pair id 0..7).
REQ-009 cursor  output  4  current slot; [3:2]=row, [1:0]=column of 4x4 grid.
REQ-010 select  output  1  one-cycle pulse per accepted btn_sel press (feeds turn scorer).
REQ-011 state  output  4  {1'b0, face value} of selected slot, valid while select=1, held otherwise.
REQ-012 empty  output  1  valid with select: 1 = slot was face-down and unmatched (legal pick), 0 = illegal pick.
REQ-013 player  output  1  player to move, 0 = J1, 1 = J2.
REQ-014 revealed  output  16  per-slot face-up mask (current turn only).
REQ-015 matched  output  16  per-slot removed-pair mask.
REQ-016 pairs_left  output  4  unmatched pairs remaining, 8..0.
REQ-017 game_over  output  1  high once pairs_left reaches 0.

Function
REQ-018 FSM states: PICK1, PICK2, SHOW, RESOLVE, DONE; one action per cycle.
REQ-019 Button priority within a cycle: btn_sel > up > down > left > right; lower-priority pulses in same cycle are dropped.
REQ-020 Cursor moves only in PICK1/PICK2; up/down change row, left/right change column, each modulo 4 (wrap within row/column, no carry between fields).
REQ-021 btn_sel in PICK1/PICK2 always produces select=1 for exactly one cycle, the cycle after the press, with state = value of slot at cursor.
REQ-022 Legal pick (slot not matched, not revealed): empty=1, revealed bit set same edge as select, FSM PICK1->PICK2 or PICK2->SHOW.
REQ-023 Illegal pick: empty=0, no mask or FSM change.
REQ-024 SHOW: counter loaded with HOLD_CYCLES, decrements each cycle; all buttons ignored; at 0 -> RESOLVE.
REQ-025 RESOLVE (one cycle): equal values -> both slots set in matched, pairs_left decremented, player unchanged; unequal -> player toggles; revealed cleared in both cases; next PICK1, or DONE if pairs_left became 0.
REQ-026 DONE: game_over=1, all buttons and load ignored until reset.
REQ-027 load accepted only in PICK1 with revealed=0 and matched=0; otherwise ignored; load has priority over buttons in same cycle (buttons dropped).
REQ-028 btn_sel pressed in SHOW, RESOLVE or DONE produces no select pulse.

Reset
REQ-029 On rst: FSM=PICK1, cursor=0, select=0, state=0, empty=0, player=0, revealed=0, matched=0, pairs_left=8, game_over=0, hold counter=0.
REQ-030 On rst card memory reinitialised to slot i value = i>>1; reset mid-turn discards revealed cards and pending resolution.

Verification
REQ-031 Reset, btn_left once -> cursor=3 (column wrap); btn_up once from 0 -> cursor=12.
REQ-032 Reset, select slot 0 then slot 1 -> select pulses with state=0, empty=1 both; after HOLD_CYCLES+1 cycles matched=16'h0003, pairs_left=7, player=0.
REQ-033 Reset, select slot 0 then slot 2 -> after resolution matched=0, revealed=0, player=1.
REQ-034 Select slot 0 twice in PICK2 -> second pulse empty=0, FSM stays PICK2; btn_sel during SHOW -> no select pulse.
REQ-035 Match all 8 default pairs -> pairs_left=0, game_over=1; further btn_sel/load ignored; rst asserted mid-SHOW -> outputs at reset values asynchronously.
